// File: rtl/alu32.sv
// 32-bit AND/ADD/SUB/OR ALU with registered result, zero and carry flags.
// Optional signed-overflow output is enabled by defining ALU32_OVF_EN.
module alu32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic [1:0]       AluOp,
`ifdef ALU32_OVF_EN
    output logic             OverflowFlag,
`endif
    output logic [WIDTH-1:0] Z,
    output logic             ZeroFlag,
    output logic             CarryFlag
);

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    logic [WIDTH:0]   sumExt_s;
    logic [WIDTH-1:0] result_s;
    logic             carry_s;
    logic             zero_s;
    logic             overflow_s;

    // Combinational core: SUB reuses the adder as X + ~Y + 1 so carry means no-borrow.
    always_comb begin
        sumExt_s   = {1'b0, {WIDTH{1'b0}}};
        result_s   = {WIDTH{1'b0}};
        carry_s    = 1'b0;
        overflow_s = 1'b0;
        case (AluOp)
            OP_AND: begin
                result_s = X & Y;
            end
            OP_ADD: begin
                sumExt_s   = {1'b0, X} + {1'b0, Y};
                result_s   = sumExt_s[WIDTH-1:0];
                carry_s    = sumExt_s[WIDTH];
                overflow_s = (X[WIDTH-1] == Y[WIDTH-1]) && (sumExt_s[WIDTH-1] != X[WIDTH-1]);
            end
            OP_SUB: begin
                sumExt_s   = {1'b0, X} + {1'b0, ~Y} + {{WIDTH{1'b0}}, 1'b1};
                result_s   = sumExt_s[WIDTH-1:0];
                carry_s    = sumExt_s[WIDTH];
                overflow_s = (X[WIDTH-1] != Y[WIDTH-1]) && (sumExt_s[WIDTH-1] != X[WIDTH-1]);
            end
            OP_OR: begin
                result_s = X | Y;
            end
            default: begin
                result_s = {WIDTH{1'b0}};
            end
        endcase
        zero_s = (result_s == {WIDTH{1'b0}});
    end

    // Output register: async reset clears everything, in-flight result is discarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Z         <= {WIDTH{1'b0}};
            ZeroFlag  <= 1'b0;
            CarryFlag <= 1'b0;
        end else begin
            Z         <= result_s;
            ZeroFlag  <= zero_s;
            CarryFlag <= carry_s;
        end
    end

`ifdef ALU32_OVF_EN
    // Signed-overflow register, same latency and reset as the other flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            OverflowFlag <= 1'b0;
        end else begin
            OverflowFlag <= overflow_s;
        end
    end
`else
    logic unusedOvf_s;
    assign unusedOvf_s = overflow_s;
`endif

endmodule

// File: tb/tb_alu32.sv
// Scoreboard bench for alu32: the driver queues hand-computed results, a monitor
// pops and compares one entry after every clock edge that captured an operation.
module tb_alu32;

    logic        clk;
    logic        rst_n;
    logic [31:0] X;
    logic [31:0] Y;
    logic [1:0]  AluOp;
    logic [31:0] Z;
    logic        ZeroFlag;
    logic        CarryFlag;
    logic        OverflowFlag;

    typedef struct {
        logic [31:0] z;
        logic        zero;
        logic        carry;
        logic        ovf;
        string       name;
    } expT;

    expT expQ[$];
    int  checks = 0;
    int  errors = 0;

    alu32 dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .X            (X),
        .Y            (Y),
        .AluOp        (AluOp),
`ifdef ALU32_OVF_EN
        .OverflowFlag (OverflowFlag),
`endif
        .Z            (Z),
        .ZeroFlag     (ZeroFlag),
        .CarryFlag    (CarryFlag)
    );

`ifndef ALU32_OVF_EN
    assign OverflowFlag = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Drive one operation between edges and queue its expected response.
    task automatic doOp(input logic [31:0] x, input logic [31:0] y, input logic [1:0] op,
                        input logic [31:0] ez, input logic ezero, input logic ec,
                        input logic eo, input string nm);
        expT e;
        @(negedge clk);
        X = x;
        Y = y;
        AluOp = op;
        e.z = ez; e.zero = ezero; e.carry = ec; e.ovf = eo; e.name = nm;
        expQ.push_back(e);
    endtask

    // Monitor: every edge that has a queued op is checked just after the edge.
    always @(posedge clk) begin
        expT e;
        #1;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkVal({e.name, ".Z"}, Z, e.z);
            checkVal({e.name, ".Zero"}, {31'd0, ZeroFlag}, {31'd0, e.zero});
            checkVal({e.name, ".Carry"}, {31'd0, CarryFlag}, {31'd0, e.carry});
`ifdef ALU32_OVF_EN
            checkVal({e.name, ".Ovf"}, {31'd0, OverflowFlag}, {31'd0, e.ovf});
`endif
        end
    end

    initial begin
        rst_n = 1'b0;
        X = 32'hDEAD_BEEF;
        Y = 32'h1234_5678;
        AluOp = 2'b01;
        #2;
        checkVal("rst.Z", Z, 32'h0);
        checkVal("rst.flags", {29'd0, ZeroFlag, CarryFlag, OverflowFlag}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        checkVal("rstHeld.Z", Z, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        doOp(32'hAAAA_5555, 32'hFFFF_0000, 2'b00, 32'hAAAA_0000, 1'b0, 1'b0, 1'b0, "and");
        doOp(32'hF0F0_F0F0, 32'h0F0F_0F0F, 2'b00, 32'h0000_0000, 1'b1, 1'b0, 1'b0, "andZero");
        doOp(32'hAAAA_5555, 32'h1122_0000, 2'b01, 32'hBBCC_5555, 1'b0, 1'b0, 1'b0, "add");
        doOp(32'hFFFF_FFFF, 32'h0000_0001, 2'b01, 32'h0000_0000, 1'b1, 1'b1, 1'b0, "addWrap");
        doOp(32'h7FFF_FFFF, 32'h0000_0001, 2'b01, 32'h8000_0000, 1'b0, 1'b0, 1'b1, "addOvf");
        doOp(32'hAAAA_FFFF, 32'h2222_3344, 2'b10, 32'h8888_CCBB, 1'b0, 1'b1, 1'b0, "sub1");
        doOp(32'hAAAA_FFFF, 32'h4512_ACD2, 2'b10, 32'h6598_532D, 1'b0, 1'b1, 1'b1, "sub2");
        doOp(32'hAAAA_FFFF, 32'hAAAA_FFFF, 2'b10, 32'h0000_0000, 1'b1, 1'b1, 1'b0, "subEq");
        doOp(32'h0000_0001, 32'h0000_0002, 2'b10, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, "subBorrow");
        doOp(32'h8000_0000, 32'h0000_0001, 2'b10, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b1, "subOvf");
        doOp(32'h0000_0000, 32'h0000_0000, 2'b11, 32'h0000_0000, 1'b1, 1'b0, 1'b0, "orZero");
        doOp(32'hF0F0_0000, 32'h0F0F_0000, 2'b11, 32'hFFFF_0000, 1'b0, 1'b0, 1'b0, "or");

        // Pulse reset between edges with the OR still on the inputs.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkVal("midRst.Z", Z, 32'h0);
        checkVal("midRst.flags", {29'd0, ZeroFlag, CarryFlag, OverflowFlag}, 32'h0);
        #1;
        rst_n = 1'b1;
        begin
            expT e;
            e.z = 32'hFFFF_0000; e.zero = 1'b0; e.carry = 1'b0; e.ovf = 1'b0; e.name = "recover";
            expQ.push_back(e);
        end

        repeat (4) @(posedge clk);
        #2;
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", expQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
